// File: rtl/posit_defines_es3.sv
// Shared constants and operand type for the 32-bit, es=3 posit datapath.
package posit_defines_es3;

  localparam int NBITS = 32;
  localparam int ES    = 3;
  localparam int FBITS = 26;
  localparam int ABITS = 30;
  localparam int SBITS = 9;

  localparam int               POSIT_MAXSCALE = 240;
  localparam logic [NBITS-1:0] POSIT_NAR      = 32'h8000_0000;
  localparam logic [NBITS-1:0] POSIT_MAXPOS   = 32'h7FFF_FFFF;

  // Unrounded operand: hidden 1 implied, fraction[29:4] real bits, fraction[3:0] extension
  typedef struct packed {
    logic                    sign;
    logic signed [SBITS-1:0] scale;
    logic [ABITS-1:0]        fraction;
    logic                    inf;
    logic                    zero;
  } value_sum;

endpackage

// File: rtl/posit_round_es3.sv
// Round-to-nearest-even, saturate and negate a posit magnitude into a packed word.
module posit_round_es3
  import posit_defines_es3::*;
(
  input  logic [NBITS-2:0] mag_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic             sign_i,
  output logic [NBITS-1:0] posit_o
);

  // Carry out of the 31-bit body can only happen from all-ones; hold at maxpos there.
  function automatic logic [NBITS-2:0] rne_sat(input logic [NBITS-2:0] m,
                                               input logic g, input logic s);
    logic [NBITS-1:0] sum;
    sum = {1'b0, m} + {{(NBITS-1){1'b0}}, g & (m[0] | s)};
    if (sum[NBITS-1]) return POSIT_MAXPOS[NBITS-2:0];
    return sum[NBITS-2:0];
  endfunction

  logic [NBITS-2:0] mag_r;

  // Rounded magnitude, then two's complement for negative values
  always_comb begin
    mag_r   = rne_sat(mag_i, guard_i, sticky_i);
    posit_o = sign_i ? (~{1'b0, mag_r} + {{(NBITS-1){1'b0}}, 1'b1}) : {1'b0, mag_r};
  end

endmodule

// File: rtl/posit_encode_es3.sv
// Three-stage posit(32,3) encoder with valid/ready flow control and collapsing bubbles.
module posit_encode_es3
  import posit_defines_es3::*;
(
  input  logic             clk,
  input  logic             reset,
  input  value_sum         in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] out_posit,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = SBITS - 1 - ES;            // regime shift amount width
  localparam int BW  = 2 + ES + ABITS + NBITS - 1; // regime seed + e + fraction + headroom

  typedef struct packed {
    logic             nar;
    logic             zero;
    logic             clamp_hi;
    logic             clamp_lo;
    logic             sign;
    logic             rneg;
    logic [SHW-1:0]   shamt;
    logic [ES-1:0]    e;
    logic [ABITS-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic             nar;
    logic             sign;
    logic [NBITS-2:0] mag;
    logic             guard;
    logic             sticky;
  } s2_t;

  logic             vld_p1_q, vld_p2_q, vld_p3_q;
  logic             adv_p1, adv_p2, adv_p3;
  s1_t              data_p1_d, data_p1_q;
  s2_t              data_p2_d, data_p2_q;
  logic [NBITS-1:0] posit_p3_d, posit_p3_q, word_s3;
  logic signed [BW-1:0] body_s2;

  assign adv_p3    = !vld_p3_q | out_ready;
  assign adv_p2    = !vld_p2_q | adv_p3;
  assign adv_p1    = !vld_p1_q | adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p3_q;
  assign out_posit = posit_p3_q;

  // S1: specials, clamp flags, k/e split; scale[7:3] is k mod 32 and scale sign is k sign
  always_comb begin
    data_p1_d          = '0;
    data_p1_d.nar      = in_value.inf;
    data_p1_d.zero     = in_value.zero;
    data_p1_d.clamp_hi = in_value.scale > POSIT_MAXSCALE;
    data_p1_d.clamp_lo = in_value.scale < -POSIT_MAXSCALE;
    data_p1_d.sign     = in_value.sign;
    data_p1_d.rneg     = in_value.scale[SBITS-1];
    data_p1_d.shamt    = in_value.scale[SBITS-1] ? ~in_value.scale[SBITS-2:ES]
                                                 : in_value.scale[SBITS-2:ES];
    data_p1_d.e        = in_value.scale[ES-1:0];
    data_p1_d.frac     = in_value.fraction;
  end

  // S2: arithmetic shift of the seed {~neg, neg} grows the regime run; split body/guard/sticky
  always_comb begin
    body_s2 = $signed({~data_p1_q.rneg, data_p1_q.rneg, data_p1_q.e, data_p1_q.frac,
                       {(NBITS-1){1'b0}}}) >>> data_p1_q.shamt;
    data_p2_d        = '0;
    data_p2_d.nar    = data_p1_q.nar;
    data_p2_d.sign   = data_p1_q.sign;
    data_p2_d.mag    = body_s2[BW-1 -: NBITS-1];
    data_p2_d.guard  = body_s2[BW-NBITS];
    data_p2_d.sticky = |body_s2[BW-NBITS-1:0];
    if (data_p1_q.nar) begin
      data_p2_d.mag    = '0;
      data_p2_d.guard  = 1'b0;
      data_p2_d.sticky = 1'b0;
    end else if (data_p1_q.zero) begin
      data_p2_d.sign   = 1'b0;
      data_p2_d.mag    = '0;
      data_p2_d.guard  = 1'b0;
      data_p2_d.sticky = 1'b0;
    end else if (data_p1_q.clamp_hi || data_p1_q.clamp_lo) begin
      data_p2_d.mag    = data_p1_q.clamp_hi ? POSIT_MAXPOS[NBITS-2:0]
                                            : {{(NBITS-2){1'b0}}, 1'b1};
      data_p2_d.guard  = 1'b0;
      data_p2_d.sticky = 1'b0;
    end
  end

  // S3: round, saturate, negate; NaR bypasses the rounder
  posit_round_es3 u_round (
    .mag_i    (data_p2_q.mag),
    .guard_i  (data_p2_q.guard),
    .sticky_i (data_p2_q.sticky),
    .sign_i   (data_p2_q.sign),
    .posit_o  (word_s3)
  );

  assign posit_p3_d = data_p2_q.nar ? POSIT_NAR : word_s3;

  // Stage valid bits: each stage refills from its predecessor whenever it advances
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (adv_p1) vld_p1_q <= in_valid;
      if (adv_p2) vld_p2_q <= vld_p1_q;
      if (adv_p3) vld_p3_q <= vld_p2_q;
    end
  end

  // Stage payloads load only when a valid item moves in
  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) data_p1_q <= data_p1_d;
    if (adv_p2 && vld_p1_q) data_p2_q <= data_p2_d;
  end

  // Output word: cleared on reset, held while stalled
  always_ff @(posedge clk) begin
    if (reset)                   posit_p3_q <= '0;
    else if (adv_p3 && vld_p2_q) posit_p3_q <= posit_p3_d;
  end

endmodule

// File: tb/tb_posit_encode_es3.sv
// Bench for posit_encode_es3: directed encodings, flow control, reset, random regression.
module tb_posit_encode_es3;
  import posit_defines_es3::*;

  logic        clk = 1'b0;
  logic        reset;
  value_sum    in_value;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_posit;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  bit sb_en    = 1'b0;
  logic [31:0] exp_q[$];

  posit_encode_es3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_posit (out_posit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference posit(32,3) encoder built from the bit-string definition
  function automatic logic [31:0] ref_enc(input value_sum v);
    int    sc, e, k;
    bit    q[$];
    longint mag;
    bit    guard, sticky;
    logic [31:0] res;
    if (v.inf)  return 32'h8000_0000;
    if (v.zero) return 32'h0000_0000;
    sc = v.scale;
    if (sc > 240)       mag = 64'h7FFF_FFFF;
    else if (sc < -240) mag = 1;
    else begin
      e = ((sc % 8) + 8) % 8;
      k = (sc - e) / 8;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 29; i >= 0; i--) q.push_back(v.fraction[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + (q[i] ? 1 : 0);
      guard  = q[31];
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky |= q[i];
      if (guard && ((mag % 2 == 1) || sticky)) mag = mag + 1;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
    end
    res = 32'(mag);
    if (v.sign) res = (~res) + 32'd1;
    return res;
  endfunction

  function automatic value_sum mk(input bit s, input int sc, input logic [29:0] fr,
                                  input bit inf, input bit zero);
    value_sum v;
    v.sign     = s;
    v.scale    = sc[8:0];
    v.fraction = fr;
    v.inf      = inf;
    v.zero     = zero;
    return v;
  endfunction

  function automatic value_sum rand_val();
    value_sum v;
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    v.sign     = r1[31];
    v.scale    = r1[8:0];
    v.fraction = r2[29:0];
    v.inf      = ($urandom_range(0, 31) == 0);
    v.zero     = ($urandom_range(0, 31) == 0);
    return v;
  endfunction

  // One isolated item: ready on offer, out_valid low for two cycles, then result at latency 3
  task automatic single(input value_sum v, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    in_value  = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, "_lat2"}, out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, "_lat3_valid"}, out_valid, 1'b1);
    chk32({tag, "_word"}, out_posit, exp);
  endtask

  // Output scoreboard: every handshake must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (sb_en && !reset && out_valid && out_ready) begin
      out_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%h expected=none", out_posit);
      end
      if (exp_q.size() != 0) chk32("sb_data", out_posit, exp_q.pop_front());
    end
  end

  initial begin
    value_sum    items[5];
    int          idx, base, sent, cyc;
    logic [31:0] held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;
    held      = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_posit", out_posit, 32'h0);
    chk1("rst_in_ready", in_ready, 1'b1);

    single(mk(0, 0, 30'h0, 0, 0), 32'h4000_0000, "one");
    single(mk(1, 0, 30'h0, 0, 0), 32'hC000_0000, "minus_one");
    single(mk(0, -1, 30'h0, 0, 0), 32'h3C00_0000, "half");
    single(mk(0, 8, 30'h0, 0, 0), 32'h6000_0000, "scale8");
    single(mk(0, 5, 30'h0, 1, 0), 32'h8000_0000, "nar");
    single(mk(1, 5, 30'h3FFF_FFFF, 0, 1), 32'h0000_0000, "zero");
    single(mk(0, 255, 30'h0, 0, 0), 32'h7FFF_FFFF, "clamp_hi");
    single(mk(0, 241, 30'h0, 0, 0), 32'h7FFF_FFFF, "clamp_hi_edge");
    single(mk(1, 255, 30'h0, 0, 0), 32'h8000_0001, "clamp_hi_neg");
    single(mk(0, -256, 30'h0, 0, 0), 32'h0000_0001, "clamp_lo");
    single(mk(0, -241, 30'h0, 0, 0), 32'h0000_0001, "clamp_lo_edge");
    single(mk(0, -240, 30'h0, 0, 0), 32'h0000_0001, "minpos_exact");
    single(mk(0, 240, 30'h0000_000F, 0, 0), 32'h7FFF_FFFF, "maxpos_nowrap");
    single(mk(0, 0, {26'h0, 4'b1000}, 0, 0), 32'h4000_0000, "rne_tie_even");
    single(mk(0, 0, {26'h1, 4'b1000}, 0, 0), 32'h4000_0002, "rne_tie_odd");
    single(mk(0, 0, {26'h3FF_FFFF, 4'b1000}, 0, 0), 32'h4400_0000, "rne_carry");
    single(mk(0, 0, {26'h0, 4'b0100}, 0, 0), 32'h4000_0000, "rne_below_half");

    // Backpressure: five offers, output stalled for six cycles
    @(posedge clk); #1;
    sb_en = 1'b1;
    base  = out_cnt;
    for (int i = 0; i < 5; i++) begin
      items[i] = rand_val();
      items[i].inf  = 1'b0;
      items[i].zero = 1'b0;
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (idx < 5) begin
        in_valid = 1'b1;
        in_value = items[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        chk32("bp_accepted", idx, 3);
        chk1("bp_in_ready_low", in_ready, 1'b0);
        chk1("bp_out_valid", out_valid, 1'b1);
        held = out_posit;
      end
      if (c == 5) begin
        chk1("bp_stable_valid", out_valid, 1'b1);
        chk32("bp_stable_word", out_posit, held);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(items[idx]));
        idx++;
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (idx < 5) begin
        in_valid = 1'b1;
        in_value = items[idx];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(items[idx]));
        idx++;
      end
      if (idx == 5 && exp_q.size() == 0) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk32("bp_drained", exp_q.size(), 0);
    chk32("bp_out_count", out_cnt - base, 5);

    // Reset with two items in flight: nothing may emerge afterwards
    in_value  = rand_val();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_value = rand_val();
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk1("rst_mid_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("rst_mid_no_stale", out_valid, 1'b0);
    end

    // Random regression with random output stalls
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_value  = rand_val();
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(in_value));
        sent++;
      end
    end
    chk32("rnd_sent", sent, 10000);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    chk32("rnd_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
